// File: rtl/uart_tx.sv
// 8N1 (optionally 8N2) UART transmitter with built-in baud counter and a
// valid/ready byte handshake that allows zero-gap back-to-back frames.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned BAUD_DIV  = 5208,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned   CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          line_q, line_d;
    logic          bit_end, accept;

    always_comb begin
        bit_end   = (cnt_q == CNT_LAST);
        tx_done   = (state_q == STOP) && bit_end && (bit_idx_q == STOP_LAST);
        tx_ready  = (state_q == IDLE) || tx_done;
        tx_busy   = (state_q != IDLE);
        accept    = tx_valid && tx_ready;

        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) bit_idx_d = bit_idx_q + 3'd1;
                if (tx_done) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                end
            end
            default: ;
        endcase

        // Acceptance in the last stop cycle overrides the return to IDLE.
        if (accept) begin
            state_d   = START;
            shift_d   = tx_data;
            cnt_d     = '0;
            bit_idx_d = '0;
        end

        // The line flop is loaded with the level of the state being entered.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
        end
    end

    assign rs232_tx = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, back-to-back, mid-frame data
// change, two stop bits, asynchronous reset mid-frame and default baud rate.
`timescale 1ns/1ps
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       valid16, valid4, valid_def;
    logic       ready16, line16, busy16, done16;
    logic       ready4, line4, busy4, done4;
    logic       ready_def, line_def, busy_def, done_def;
    logic       sel4;
    logic       m_line, m_busy, m_done, m_ready;

    int errors = 0;
    int checks = 0;

    logic ln [0:511];
    logic bz [0:511];
    logic dn [0:511];
    logic rd [0:511];

    always #10 clk = ~clk;

    uart_tx #(.BAUD_DIV(16), .STOP_BITS(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid16),
        .tx_ready(ready16), .rs232_tx(line16), .tx_busy(busy16), .tx_done(done16)
    );

    uart_tx #(.BAUD_DIV(4), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid4),
        .tx_ready(ready4), .rs232_tx(line4), .tx_busy(busy4), .tx_done(done4)
    );

    uart_tx u_dutdef (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_def),
        .tx_ready(ready_def), .rs232_tx(line_def), .tx_busy(busy_def), .tx_done(done_def)
    );

    assign m_line  = sel4 ? line4  : line16;
    assign m_busy  = sel4 ? busy4  : busy16;
    assign m_done  = sel4 ? done4  : done16;
    assign m_ready = sel4 ? ready4 : ready16;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel4) valid4 = v;
        else      valid16 = v;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        check("ready_before_send", {31'd0, m_ready}, 32'd1);
        tx_data = b;
        set_valid(1'b1);
    endtask

    // Sample j is taken in cycle k+j, k being the handshake edge after send().
    task automatic record(input int n, input int drop_at, input int chg_at, input logic [7:0] chg_val);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            ln[j] = m_line;
            bz[j] = m_busy;
            dn[j] = m_done;
            rd[j] = m_ready;
            if (j == drop_at) set_valid(1'b0);
            if (j == chg_at)  tx_data = chg_val;
        end
    endtask

    task automatic check_frame(input string tag, input int off, input logic [7:0] b,
                               input int bd, input int s);
        int frame;
        int cs, cd, cst, cdone, crdy, cbusy, p, slot;
        logic [7:0] dec;
        frame = (9 + s) * bd;
        cs = 0; cd = 0; cst = 0; cdone = 0; crdy = 0; cbusy = 0;
        for (int j = 1; j <= frame; j++) begin
            p    = off + j;
            slot = (j - 1) / bd;
            if (slot == 0) begin
                if (ln[p] === 1'b0) cs++;
            end else if (slot <= 8) begin
                if (ln[p] === b[slot-1]) cd++;
            end else begin
                if (ln[p] === 1'b1) cst++;
            end
            if (dn[p] === 1'b1) cdone++;
            if (rd[p] === 1'b1) crdy++;
            if (bz[p] === 1'b1) cbusy++;
        end
        for (int i = 0; i < 8; i++) dec[i] = ln[off + 1 + (i + 1) * bd + bd / 2];
        check({tag, "_start_cycles"}, cs, bd);
        check({tag, "_data_cycles"}, cd, 8 * bd);
        check({tag, "_stop_cycles"}, cst, s * bd);
        check({tag, "_decoded"}, {24'd0, dec}, {24'd0, b});
        check({tag, "_done_count"}, cdone, 1);
        check({tag, "_done_last"}, {31'd0, dn[off + frame]}, 32'd1);
        check({tag, "_ready_count"}, crdy, 1);
        check({tag, "_ready_last"}, {31'd0, rd[off + frame]}, 32'd1);
        check({tag, "_busy_cycles"}, cbusy, frame);
    endtask

    initial begin
        int n, cnt;
        rst_n = 1'b0;
        tx_data = 8'h00;
        valid16 = 1'b0; valid4 = 1'b0; valid_def = 1'b0;
        sel4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line16", {31'd0, line16}, 32'd1);
        check("rst_ready16", {31'd0, ready16}, 32'd1);
        check("rst_busy16", {31'd0, busy16}, 32'd0);
        check("rst_done16", {31'd0, done16}, 32'd0);
        check("rst_line4", {31'd0, line4}, 32'd1);
        rst_n = 1'b1;

        // Default divider: start bit lasts 5208 cycles (bit 0 of 0x01 is high).
        @(negedge clk);
        tx_data = 8'h01;
        valid_def = 1'b1;
        @(negedge clk);
        valid_def = 1'b0;
        n = 0;
        while (line_def === 1'b0 && n < 6000) begin
            n++;
            @(negedge clk);
        end
        check("def_start_width", n, 5208);

        // Single byte.
        send(8'h55);
        record(164, 1, 0, 8'h00);
        check_frame("single55", 0, 8'h55, 16, 1);
        check("single55_idle_after", {31'd0, ln[164]}, 32'd1);

        // Back-to-back with valid held; second byte presented mid-frame.
        send(8'hA3);
        record(324, 161, 1, 8'h0F);
        check_frame("b2b_A3", 0, 8'hA3, 16, 1);
        check_frame("b2b_0F", 160, 8'h0F, 16, 1);
        cnt = 0;
        for (int j = 1; j <= 324; j++) if (dn[j] === 1'b1) cnt++;
        check("b2b_done_total", cnt, 2);
        check("b2b_no_gap", {30'd0, ln[160], ln[161]}, 32'd2);

        // Data change while busy must not affect the frame in flight.
        send(8'hFF);
        record(164, 1, 40, 8'h00);
        check_frame("chg_FF", 0, 8'hFF, 16, 1);
        send(8'h00);
        record(164, 1, 0, 8'h00);
        check_frame("chg_00", 0, 8'h00, 16, 1);

        // Two stop bits.
        sel4 = 1'b1;
        send(8'h80);
        record(48, 1, 0, 8'h00);
        check_frame("stop2_80", 0, 8'h80, 4, 2);
        check("stop2_done_at_44", {31'd0, dn[44]}, 32'd1);
        sel4 = 1'b0;

        // Reset during data bit 3 of 0xA5 (bit 3 is low).
        send(8'hA5);
        record(70, 1, 0, 8'h00);
        check("rstmid_line_pre", {31'd0, m_line}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid_line", {31'd0, line16}, 32'd1);
        check("rstmid_ready", {31'd0, ready16}, 32'd1);
        check("rstmid_busy", {31'd0, busy16}, 32'd0);
        record(4, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        record(20, 0, 0, 8'h00);
        cnt = 0;
        n = 0;
        for (int j = 1; j <= 20; j++) begin
            if (dn[j] === 1'b1) cnt++;
            if (ln[j] === 1'b1 && rd[j] === 1'b1) n++;
        end
        check("rstmid_no_done", cnt, 0);
        check("rstmid_idle_after", n, 20);
        send(8'h3C);
        record(164, 1, 0, 8'h00);
        check_frame("rstmid_3C", 0, 8'h3C, 16, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
